riscv_multicycle_controller: RTL and testbench

//  Moore-style control FSM that sequences the multicycle RISC-V datapath: PC, instruction register,

---
 rtl/riscv_ctrl_pkg.sv | 58 +++++
 rtl/riscv_alu_decoder.sv | 31 +++
 rtl/riscv_multicycle_controller.sv | 158 +++++++++++++++
 tb/tb_riscv_multicycle_controller.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V controller: states, opcodes, extend selects,
// ALU operations and datapath mux selects.
package riscv_ctrl_pkg;

  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecR,
    StExecI,
    StAluWb,
    StBeq,
    StJal,
    StIllegal
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Request to the ALU decoder: fixed add/sub, or decode funct fields as R- or I-type.
  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/riscv_alu_decoder.sv
// Combinational ALU control decode from the controller's ALU request and the funct fields.
module riscv_alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [2:0] alu_control,
  output logic       bad_funct
);

  always_comb begin
    alu_control = ALU_ADD;
    bad_funct   = 1'b0;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      default: begin
        case (funct3)
          // funct7b5 only selects sub for R-type; addi has no subtract form
          3'b000:  alu_control = (alu_op == ALUOP_R && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b111:  alu_control = ALU_AND;
          3'b110:  alu_control = ALU_OR;
          3'b010:  alu_control = ALU_SLT;
          default: bad_funct = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/riscv_multicycle_controller.sv
// Moore control FSM sequencing the multicycle RISC-V datapath over a req/ready memory port.
module riscv_multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter bit USE_MEM_RDY = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic [1:0] imm_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [2:0] alu_control,
  output logic       illegal
);

  state_e     state_q, state_d;
  logic       illegal_q;
  logic       rdy;
  logic [1:0] alu_op;
  logic       bad_funct;
  logic       pc_update, branch;
  logic       ir_write_raw, reg_write_raw, mem_write_raw;

  assign rdy = USE_MEM_RDY ? mem_ready : 1'b1;

  riscv_alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .alu_control (alu_control),
    .bad_funct   (bad_funct)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == StIllegal) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:  if (rdy) state_d = StDecode;
      StDecode: begin
        case (opcode)
          OP_LW, OP_SW: state_d = StMemAdr;
          OP_R:         state_d = StExecR;
          OP_I:         state_d = StExecI;
          OP_BEQ:       state_d = StBeq;
          OP_JAL:       state_d = StJal;
          default:      state_d = StIllegal;
        endcase
      end
      StMemAdr:         state_d = (opcode == OP_SW) ? StMemWrite : StMemRead;
      StMemRead:        if (rdy) state_d = StMemWb;
      StMemWb:          state_d = StFetch;
      StMemWrite:       if (rdy) state_d = StFetch;
      StExecR, StExecI: state_d = bad_funct ? StIllegal : StAluWb;
      StAluWb, StBeq:   state_d = StFetch;
      StJal:            state_d = StAluWb;
      StIllegal:        state_d = StIllegal;
      default:          state_d = StFetch;
    endcase
  end

  always_comb begin
    mem_req       = 1'b0;
    adr_src       = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    mem_write_raw = 1'b0;
    pc_update     = 1'b0;
    branch        = 1'b0;
    imm_src       = IMM_I;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    result_src    = RES_ALUOUT;
    alu_op        = ALUOP_ADD;
    case (state_q)
      StFetch: begin
        mem_req      = 1'b1;
        alu_src_b    = SRCB_FOUR;
        result_src   = RES_ALU;
        ir_write_raw = rdy;
        pc_update    = rdy;
      end
      StDecode: begin
        // Precompute the jump/branch target into ALUOut for the following state
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = (opcode == OP_JAL) ? IMM_J : IMM_B;
      end
      StMemAdr: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        imm_src   = (opcode == OP_SW) ? IMM_S : IMM_I;
      end
      StMemRead: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      StMemWb: begin
        result_src    = RES_DATA;
        reg_write_raw = 1'b1;
      end
      StMemWrite: begin
        mem_req       = 1'b1;
        adr_src       = 1'b1;
        mem_write_raw = rdy;
      end
      StExecR: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_R;
      end
      StExecI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_I;
      end
      StAluWb: reg_write_raw = 1'b1;
      StBeq: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
      end
      StJal: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  // No write strobe may escape while reset is held, whatever state we are in
  assign ir_write  = ir_write_raw & ~reset;
  assign pc_write  = (pc_update | (branch & zero)) & ~reset;
  assign reg_write = reg_write_raw & ~reset;
  assign mem_write = mem_write_raw & ~reset;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_riscv_multicycle_controller.sv
// Directed bench for the multicycle controller: an instruction-plan model checked every cycle,
// plus literal expectations at the interesting cycles of each scenario.
module tb_riscv_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset, funct7b5, zero, mem_ready;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       mem_req, adr_src, ir_write, pc_write, reg_write, mem_write, illegal;
  logic [1:0] imm_src, alu_src_a, alu_src_b, result_src;
  logic [2:0] alu_control;

  typedef struct packed {
    logic       mem_req, adr_src, ir_write, pc_write, reg_write, mem_write;
    logic [1:0] imm, a, b, rs;
    logic [2:0] alu;
    logic       illegal;
  } outs_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  string plan[$];
  bit    model_valid = 1'b0;
  bit    illegal_m   = 1'b0;

  riscv_multicycle_controller dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .adr_src     (adr_src),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .reg_write   (reg_write),
    .mem_write   (mem_write),
    .imm_src     (imm_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .result_src  (result_src),
    .alu_control (alu_control),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  // Current micro-step of the instruction in flight; an empty plan means fetching.
  function automatic string cur_step();
    return (plan.size() > 0) ? plan[0] : "fetch";
  endfunction

  function automatic logic [2:0] alu_map(input logic [2:0] f3, input logic f7, input bit is_r,
                                         output bit bad);
    bad = 1'b0;
    case (f3)
      3'b000: return (is_r && f7) ? 3'b001 : 3'b000;
      3'b111: return 3'b010;
      3'b110: return 3'b011;
      3'b010: return 3'b101;
      default: begin
        bad = 1'b1;
        return 3'b000;
      end
    endcase
  endfunction

  function automatic outs_t expect_outs(input string s);
    outs_t e;
    bit    bad;
    e = '0;
    if (s == "fetch") begin
      e.mem_req = 1; e.b = 2'b10; e.rs = 2'b10; e.ir_write = mem_ready; e.pc_write = mem_ready;
    end else if (s == "decode") begin
      e.a = 2'b01; e.b = 2'b01; e.imm = (opcode == 7'b1101111) ? 2'b11 : 2'b10;
    end else if (s == "memadr") begin
      e.a = 2'b10; e.b = 2'b01; e.imm = (opcode == 7'b0100011) ? 2'b01 : 2'b00;
    end else if (s == "memread") begin
      e.mem_req = 1; e.adr_src = 1;
    end else if (s == "memwb") begin
      e.rs = 2'b01; e.reg_write = 1;
    end else if (s == "memwrite") begin
      e.mem_req = 1; e.adr_src = 1; e.mem_write = mem_ready;
    end else if (s == "execr") begin
      e.a = 2'b10; e.alu = alu_map(funct3, funct7b5, 1'b1, bad);
    end else if (s == "execi") begin
      e.a = 2'b10; e.b = 2'b01; e.alu = alu_map(funct3, funct7b5, 1'b0, bad);
    end else if (s == "aluwb") begin
      e.reg_write = 1;
    end else if (s == "beq") begin
      e.a = 2'b10; e.alu = 3'b001; e.pc_write = zero;
    end else if (s == "jal") begin
      e.a = 2'b01; e.b = 2'b10; e.pc_write = 1;
    end
    e.illegal = illegal_m;
    if (reset) begin
      e.ir_write = 0; e.pc_write = 0; e.reg_write = 0; e.mem_write = 0;
    end
    return e;
  endfunction

  // Plan model: on fetch completion the instruction is queued, decode expands it into its steps.
  always @(posedge clk) begin
    string s;
    bit    bad;
    if (reset) begin
      plan.delete();
      illegal_m   = 1'b0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      s = cur_step();
      if (s == "fetch") begin
        if (mem_ready) plan.push_back("decode");
      end else if (s == "decode") begin
        void'(plan.pop_front());
        case (opcode)
          7'b0000011: begin plan.push_back("memadr"); plan.push_back("memread");
                            plan.push_back("memwb"); end
          7'b0100011: begin plan.push_back("memadr"); plan.push_back("memwrite"); end
          7'b0110011: begin plan.push_back("execr"); plan.push_back("aluwb"); end
          7'b0010011: begin plan.push_back("execi"); plan.push_back("aluwb"); end
          7'b1100011: plan.push_back("beq");
          7'b1101111: begin plan.push_back("jal"); plan.push_back("aluwb"); end
          default:    plan.push_back("illegal");
        endcase
      end else if (s == "execr" || s == "execi") begin
        void'(alu_map(funct3, funct7b5, s == "execr", bad));
        void'(plan.pop_front());
        if (bad) begin
          plan.delete();
          plan.push_back("illegal");
        end
      end else if (s == "memread" || s == "memwrite") begin
        if (mem_ready) void'(plan.pop_front());
      end else if (s != "illegal") begin
        void'(plan.pop_front());
      end
      if (cur_step() == "illegal") illegal_m = 1'b1;
    end
  end

  always @(negedge clk) begin
    outs_t e, a;
    if (model_valid) begin
      e = expect_outs(cur_step());
      a = {mem_req, adr_src, ir_write, pc_write, reg_write, mem_write, imm_src, alu_src_a,
           alu_src_b, result_src, alu_control, illegal};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL cycle_compare t=%0t step=%s actual=%b required=%b", $time, cur_step(), a, e);
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_step(input string exp);
    n_checks++;
    if (cur_step() != exp) begin
      n_fail++;
      $display("FAIL model_step actual=%s required=%s", cur_step(), exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input bit rdy, input bit z);
    mem_ready = rdy;
    zero      = z;
    #1;
  endtask

  initial begin
    reset = 1; opcode = 7'b0; funct3 = 3'b0; funct7b5 = 0; zero = 0; mem_ready = 0;
    tick(); tick();
    reset = 0;
    go(0, 0);
    check("rst_mem_req", 8'(mem_req), 8'h1);
    check("rst_result_src", 8'(result_src), 8'h2);
    check("rst_illegal", 8'(illegal), 8'h0);
    check("rst_ir_write", 8'(ir_write), 8'h0);
    tick();

    // lw
    opcode = 7'b0000011; funct3 = 3'b010;
    go(1, 0); check("lw_fetch_ir_write", 8'(ir_write), 8'h1); check_step("fetch"); tick();
    go(1, 0); check("lw_decode_src_a", 8'(alu_src_a), 8'h1); tick();
    go(1, 0); check("lw_memadr_imm", 8'(imm_src), 8'h0); check_step("memadr"); tick();
    go(1, 0); check("lw_memread_adr", 8'(adr_src), 8'h1);
    check("lw_memread_reg_write", 8'(reg_write), 8'h0); tick();
    go(1, 0); check("lw_memwb_reg_write", 8'(reg_write), 8'h1);
    check("lw_memwb_result", 8'(result_src), 8'h1); tick();

    // sw with two wait cycles
    opcode = 7'b0100011;
    go(1, 0); check("sw_fetch_ir_write", 8'(ir_write), 8'h1); tick();
    go(1, 0); tick();
    go(1, 0); check("sw_memadr_imm", 8'(imm_src), 8'h1); tick();
    go(0, 0); check("sw_wait1_mem_write", 8'(mem_write), 8'h0); tick();
    go(0, 0); check("sw_wait2_mem_write", 8'(mem_write), 8'h0); tick();
    go(1, 0); check("sw_ready_mem_write", 8'(mem_write), 8'h1); tick();

    // beq taken then not taken
    opcode = 7'b1100011; funct3 = 3'b000;
    go(1, 0); tick();
    go(1, 0); check("beq_decode_imm", 8'(imm_src), 8'h2); tick();
    go(1, 1); check("beq_taken_pc_write", 8'(pc_write), 8'h1); tick();
    go(1, 0); tick();
    go(1, 0); tick();
    go(1, 0); check("beq_not_taken_pc_write", 8'(pc_write), 8'h0); tick();

    // jal
    opcode = 7'b1101111;
    go(1, 0); tick();
    go(1, 0); check("jal_decode_imm", 8'(imm_src), 8'h3); tick();
    go(1, 0); check("jal_pc_write", 8'(pc_write), 8'h1); tick();
    go(1, 0); check("jal_aluwb_reg_write", 8'(reg_write), 8'h1); check_step("aluwb"); tick();
    go(1, 0); check_step("fetch");

    // R-type sub with a slow fetch
    opcode = 7'b0110011; funct3 = 3'b000; funct7b5 = 1;
    for (int i = 0; i < 3; i++) begin
      go(0, 0); check("r_fetch_wait_ir_write", 8'(ir_write), 8'h0); tick();
    end
    go(1, 0); check("r_fetch_ir_write", 8'(ir_write), 8'h1); tick();
    go(1, 0); tick();
    go(1, 0); check("r_sub_alu_control", 8'(alu_control), 8'h1); tick();
    go(1, 0); check("r_aluwb_reg_write", 8'(reg_write), 8'h1); tick();

    // ori, funct7b5 ignored
    opcode = 7'b0010011; funct3 = 3'b110;
    go(1, 0); tick();
    go(1, 0); tick();
    go(1, 0); check("ori_alu_control", 8'(alu_control), 8'h3); tick();
    go(1, 0); tick();

    // unsupported opcode
    opcode = 7'b0000000;
    go(1, 0); tick();
    go(1, 0); tick();
    for (int i = 0; i < 10; i++) begin
      go(1, 0); check("illegal_held", 8'(illegal), 8'h1);
      check("illegal_mem_req", 8'(mem_req), 8'h0); tick();
    end
    reset = 1; go(1, 0); tick();
    reset = 0;
    go(1, 0); check("post_reset_illegal", 8'(illegal), 8'h0); check_step("fetch");

    // reset while waiting in MEMREAD
    opcode = 7'b0000011; funct3 = 3'b010;
    tick();
    go(1, 0); tick();
    go(1, 0); tick();
    go(0, 0); check("lw2_memread_adr", 8'(adr_src), 8'h1); tick();
    go(0, 0); tick();
    reset = 1; go(0, 0); check("memread_reset_reg_write", 8'(reg_write), 8'h0); tick();
    reset = 0;
    go(0, 0); check("memread_reset_adr", 8'(adr_src), 8'h0);
    check("memread_reset_mem_req", 8'(mem_req), 8'h1);
    check("memread_reset_illegal", 8'(illegal), 8'h0); check_step("fetch"); tick();

    // reset during a completing fetch suppresses the strobes
    reset = 1; go(1, 0);
    check("fetch_reset_ir_write", 8'(ir_write), 8'h0);
    check("fetch_reset_pc_write", 8'(pc_write), 8'h0); tick();
    reset = 0;

    // I-type with unmapped funct3
    opcode = 7'b0010011; funct3 = 3'b001;
    go(1, 0); tick();
    go(1, 0); tick();
    go(1, 0); check("bad_funct_reg_write", 8'(reg_write), 8'h0); tick();
    go(1, 0); check("bad_funct_illegal", 8'(illegal), 8'h1);
    check("bad_funct_no_write", 8'(reg_write), 8'h0); tick();
    reset = 1; go(1, 0); tick();
    reset = 0;
    go(0, 0); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
